// File: rtl/top_level_miner.sv
// Memory-mapped single-block SHA-256 miner: hashes a 408-bit message and compares the digest against a 256-bit target.
// Optional DOUBLE_SHA_EN macro re-hashes the first digest (Bitcoin double SHA-256) before the compare.
module top_level_miner (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [4:0]  slaveAddr,
  input  logic [31:0] slaveWriteData,
  input  logic        slaveWrite,
  input  logic        slaveRead,
  input  logic        slaveChipSelect,
  output logic [31:0] slaveReadData
);

  localparam int unsigned NUM_ROUNDS = 64;
  localparam logic [5:0]  LAST_ROUND = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Register file: msg_q[15] holds msg[407:376]; tgt_stage[0] holds target[31:0]
  logic [15:3][31:0] msg_q;
  logic [7:0][31:0]  tgt_stage;
  logic [255:0]      target_q;
  logic [7:0][31:0]  digest_q;

  state_t            state_q;
  logic              busy_q, done_q, valid_q, cmp_q;
  logic [5:0]        rnd_q;
  logic [31:0]       a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  // Rolling schedule window: w_q[15] is W[t], w_q[15-k] is W[t+k]
  logic [15:0][31:0] w_q;
`ifdef DOUBLE_SHA_EN
  logic              second_q;
`endif

  logic        wr_en, start_cmd, latch_cmd;
  logic [511:0] msg_block;
  logic [31:0] t1, t2, w_new;
  logic [7:0][31:0] sum;

  assign wr_en     = slaveWrite && slaveChipSelect;
  assign start_cmd = wr_en && (slaveAddr == 5'd0) && (slaveWriteData == 32'd2);
  assign latch_cmd = wr_en && (slaveAddr == 5'd0) && (slaveWriteData == 32'd1);

  assign msg_block = {msg_q[15:4], msg_q[3][31:8], 1'b1, 39'b0, 64'd408};

  assign t1 = h_q + (ror(e_q, 6) ^ ror(e_q, 11) ^ ror(e_q, 25)) + ((e_q & f_q) ^ (~e_q & g_q))
            + K[rnd_q] + w_q[15];
  assign t2 = (ror(a_q, 2) ^ ror(a_q, 13) ^ ror(a_q, 22)) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
  assign w_new = (ror(w_q[1], 17) ^ ror(w_q[1], 19) ^ (w_q[1] >> 10)) + w_q[6]
               + (ror(w_q[14], 7) ^ ror(w_q[14], 18) ^ (w_q[14] >> 3)) + w_q[15];

  assign sum = {IV[7] + a_q, IV[6] + b_q, IV[5] + c_q, IV[4] + d_q,
                IV[3] + e_q, IV[2] + f_q, IV[1] + g_q, IV[0] + h_q};

  always_ff @(posedge clk) begin
    if (n_rst) begin
      msg_q     <= '0;
      tgt_stage <= '0;
      target_q  <= '0;
    end else if (wr_en) begin
      if (slaveAddr >= 5'd3 && slaveAddr <= 5'd15)
        msg_q[slaveAddr[3:0]] <= slaveWriteData;
      else if (slaveAddr[4:3] == 2'b10)
        tgt_stage[slaveAddr[2:0]] <= slaveWriteData;
      else if (latch_cmd)
        target_q <= tgt_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      cmp_q    <= 1'b0;
      rnd_q    <= '0;
      digest_q <= '0;
      w_q      <= '0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
`ifdef DOUBLE_SHA_EN
      second_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_cmd) begin
            w_q     <= msg_block;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= IV;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef DOUBLE_SHA_EN
            second_q <= 1'b0;
`endif
            state_q <= S_LOAD;
          end
        end
        S_LOAD: state_q <= S_ROUND;
        S_ROUND: begin
          a_q <= t1 + t2;
          b_q <= a_q;
          c_q <= b_q;
          d_q <= c_q;
          e_q <= d_q + t1;
          f_q <= e_q;
          g_q <= f_q;
          h_q <= g_q;
          w_q <= {w_q[14:0], w_new};
          rnd_q <= rnd_q + 6'd1;
          if (rnd_q == LAST_ROUND)
            state_q <= S_FINAL;
        end
        S_FINAL: begin
`ifdef DOUBLE_SHA_EN
          // First pass feeds its digest back as the padded second block
          if (!second_q) begin
            w_q      <= {sum, 1'b1, 191'b0, 64'd256};
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= IV;
            rnd_q    <= '0;
            second_q <= 1'b1;
            state_q  <= S_LOAD;
          end else
`endif
          begin
            digest_q <= sum;
            cmp_q    <= (sum < target_q);
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= cmp_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    slaveReadData = '0;
    if (slaveRead && slaveChipSelect) begin
      if (slaveAddr == 5'd0)
        slaveReadData = {29'b0, valid_q, done_q, busy_q};
      else if (slaveAddr >= 5'd3 && slaveAddr <= 5'd15)
        slaveReadData = msg_q[slaveAddr[3:0]];
      else if (slaveAddr[4:3] == 2'b10)
        slaveReadData = tgt_stage[slaveAddr[2:0]];
      else if (slaveAddr[4:3] == 2'b11)
        slaveReadData = digest_q[~slaveAddr[2:0]];
    end
  end

endmodule

// File: tb/tb_top_level_miner.sv
// Bench for top_level_miner: register vectors from a table, hash runs checked against a software SHA-256 model.
`timescale 1ns/1ps
module tb_top_level_miner;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  slaveAddr;
  logic [31:0] slaveWriteData;
  logic        slaveWrite, slaveRead, slaveChipSelect;
  logic [31:0] slaveReadData;

  top_level_miner dut (
    .clk(clk), .n_rst(n_rst), .slaveAddr(slaveAddr), .slaveWriteData(slaveWriteData),
    .slaveWrite(slaveWrite), .slaveRead(slaveRead), .slaveChipSelect(slaveChipSelect),
    .slaveReadData(slaveReadData)
  );

  always #5 clk = ~clk;

`ifdef DOUBLE_SHA_EN
  localparam int LAT = 133;
`else
  localparam int LAT = 67;
`endif

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] HT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Textbook single-block SHA-256 with a full 64-entry schedule
  function automatic logic [255:0] sha256_block(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [511:0] tmp;
    logic [255:0] r;
    tmp = blk;
    for (int i = 0; i < 16; i++) begin
      w[i] = tmp[511:480];
      tmp = tmp << 32;
    end
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = HT[i];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], HT[i] + v[i]};
    return r;
  endfunction

  logic [31:0]  msg_w [16];
  logic [255:0] tgt;

  function automatic logic [255:0] expected_digest();
    logic [511:0] blk;
    logic [255:0] h;
    blk = '0;
    for (int i = 15; i >= 4; i--) blk = {blk[479:0], msg_w[i]};
    blk = {blk[383:0], msg_w[3][31:8], 1'b1, 39'b0, 64'd408};
    h = sha256_block(blk);
`ifdef DOUBLE_SHA_EN
    h = sha256_block({h, 1'b1, 191'b0, 64'd256});
`endif
    return h;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];
  int  n_checks = 0;
  int  n_err = 0;

  always @(negedge clk) begin
    if (slaveRead) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_read: got read of addr %0d, expected no read", slaveAddr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        n_checks++;
        if (slaveReadData !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, slaveReadData, e.exp);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic cs = 1'b1);
    slaveAddr = a; slaveWriteData = d; slaveWrite = 1'b1; slaveChipSelect = cs;
    @(posedge clk); #1;
    slaveWrite = 1'b0; slaveChipSelect = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm, input logic cs = 1'b1);
    sb_t s;
    s.name = nm; s.exp = e;
    sb.push_back(s);
    slaveAddr = a; slaveRead = 1'b1; slaveChipSelect = cs;
    @(posedge clk); #1;
    slaveRead = 1'b0; slaveChipSelect = 1'b0;
  endtask

  task automatic set_target(input logic [255:0] t);
    logic [255:0] tmp;
    tmp = t;
    for (int i = 0; i < 8; i++) begin
      wr(5'(16 + i), tmp[31:0]);
      tmp = tmp >> 32;
    end
    wr(5'd0, 32'd1);
    tgt = t;
  endtask

  // Start, check busy next cycle and exact done latency, then read digest
  task automatic hash_check(input bit mid, input string tag);
    logic [255:0] h;
    logic         v;
    int           spent;
    h = expected_digest();
    v = (h < tgt);
    spent = 0;
    wr(5'd0, 32'd2);
    rd(5'd0, 32'h1, {tag, "_busy_next"});
    if (mid) begin
      idle(8);
      wr(5'd0, 32'd2);
      idle(10);
      wr(5'd10, 32'hDEADBEEF);
      wr(5'd15, 32'h12345678);
      spent = 21;
    end
    idle(LAT - 2 - spent);
    rd(5'd0, 32'h1, {tag, "_not_done_early"});
    rd(5'd0, {29'b0, v, 2'b10}, {tag, "_done_at_lat"});
    for (int i = 0; i < 8; i++) begin
      rd(5'(24 + i), h[255:224], $sformatf("%s_digest%0d", tag, i));
      h = h << 32;
    end
    rd(5'd0, {29'b0, v, 2'b10}, {tag, "_status_hold"});
    if (mid) begin
      wr(5'd10, msg_w[10]);
      wr(5'd15, msg_w[15]);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    bit          cs;
    logic [4:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] ktest;
    n_rst = 1'b1; slaveAddr = '0; slaveWriteData = '0;
    slaveWrite = 1'b0; slaveRead = 1'b0; slaveChipSelect = 1'b0;
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    tgt = '0;

    vt.push_back('{0, 1, 1, 5'd0,  32'h0,        "rst_status"});
    vt.push_back('{0, 1, 1, 5'd3,  32'h0,        "rst_msg3"});
    vt.push_back('{0, 1, 1, 5'd16, 32'h0,        "rst_tgt16"});
    vt.push_back('{0, 1, 1, 5'd24, 32'h0,        "rst_digest24"});
    vt.push_back('{1, 0, 1, 5'd1,  32'hFFFFFFFF, ""});
    vt.push_back('{0, 1, 1, 5'd1,  32'h0,        "reserved1"});
    vt.push_back('{1, 0, 1, 5'd2,  32'hFFFFFFFF, ""});
    vt.push_back('{0, 1, 1, 5'd2,  32'h0,        "reserved2"});
    vt.push_back('{1, 0, 1, 5'd23, 32'h0FFFFFFF, ""});
    for (int a = 22; a >= 16; a--) vt.push_back('{1, 0, 1, 5'(a), 32'hFFFFFFFF, ""});
    vt.push_back('{1, 0, 1, 5'd0,  32'd1,        ""});
    vt.push_back('{1, 0, 1, 5'd0,  32'd3,        ""});
    vt.push_back('{0, 1, 1, 5'd23, 32'h0FFFFFFF, "tgt23_rb"});
    for (int a = 22; a >= 16; a--) vt.push_back('{0, 1, 1, 5'(a), 32'hFFFFFFFF, $sformatf("tgt%0d_rb", a)});
    vt.push_back('{0, 1, 1, 5'd0,  32'h0,        "status_idle"});
    vt.push_back('{1, 0, 1, 5'd15, 32'h61000000, ""});
    vt.push_back('{0, 1, 1, 5'd15, 32'h61000000, "msg15_rb"});
    vt.push_back('{0, 1, 0, 5'd15, 32'h0,        "cs_gate_rd"});
    vt.push_back('{1, 0, 0, 5'd14, 32'hFFFFFFFF, ""});
    vt.push_back('{0, 1, 1, 5'd14, 32'h0,        "cs_gate_wr"});

    idle(3);
    n_rst = 1'b0;
    idle(1);

    ktest = sha256_block({32'h61626380, 416'b0, 64'd24});
    n_checks++;
    if (ktest !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      n_err++;
      $display("FAIL model_abc: got %h expected ba7816bf...f20015ad", ktest);
    end

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data, vt[i].cs);
      if (vt[i].rd) rd(vt[i].addr, vt[i].data, vt[i].name, vt[i].cs);
    end
    msg_w[15] = 32'h61000000;
    tgt = {32'h0FFFFFFF, {7{32'hFFFFFFFF}}};

    hash_check(1'b1, "msg_a_mid");
    set_target({8{32'hFFFFFFFF}});
    hash_check(1'b0, "tgt_ones");
    set_target('0);
    hash_check(1'b0, "tgt_zero");

    wr(5'd0, 32'd2);
    idle(20);
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    rd(5'd0,  32'h0, "rst_mid_status");
    rd(5'd24, 32'h0, "rst_mid_digest24");
    rd(5'd31, 32'h0, "rst_mid_digest31");
    rd(5'd15, 32'h0, "rst_mid_msg15");
    rd(5'd23, 32'h0, "rst_mid_tgt23");
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    tgt = '0;
    hash_check(1'b0, "after_rst");

    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
